// File: rtl/rr_encoder.sv
// Registered round-robin binary encoder: grants one of 2**BINBUSWIDTH request lines under a valid/ready handshake.
// Define RR_ENCODER_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority (lowest index wins).
module rr_encoder #(
    parameter int BINBUSWIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [(2**BINBUSWIDTH)-1:0]   req,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [BINBUSWIDTH-1:0]        outbinbus,
    output logic [(2**BINBUSWIDTH)-1:0]   oneshotbus,
    output logic [(2**BINBUSWIDTH)-1:0]   ack
);

    localparam int N = 2**BINBUSWIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [BINBUSWIDTH-1:0] ptr_reg, ptr_next;
    logic [BINBUSWIDTH-1:0] bin_reg, bin_next;
    logic [N-1:0]           onehot_reg, onehot_next;
    logic                   valid_reg, valid_next;

    logic [N-1:0]           masked;
    logic [BINBUSWIDTH-1:0] after_bin;
    logic [BINBUSWIDTH-1:0] sel_start;
    logic [N-1:0]           sel_rot;
    logic [BINBUSWIDTH-1:0] sel_first;
    logic [BINBUSWIDTH-1:0] sel_idx;
    logic [N-1:0]           sel_onehot;

    // The current winner is masked out so a request still high in the ack
    // overlap cycle cannot be granted twice. In IDLE onehot_reg is 0.
    assign masked = req & ~onehot_reg;

`ifdef RR_ENCODER_ROUND_ROBIN_EN
    assign after_bin = bin_reg + 1'b1;
`else
    assign after_bin = '0;
`endif

    assign sel_start = (state_reg == HOLD) ? after_bin : ptr_reg;

    // Rotate the request vector so that sel_start lands on bit 0, then a
    // plain lowest-index priority encoder finds the round-robin winner.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sel
            logic [BINBUSWIDTH-1:0] src;
            assign src            = sel_start + BINBUSWIDTH'(gi);
            assign sel_rot[gi]    = masked[src];
            assign sel_onehot[gi] = (sel_idx == BINBUSWIDTH'(gi));
        end
    endgenerate

    always_comb begin
        sel_first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel_rot[i]) begin
                sel_first = BINBUSWIDTH'(i);
            end
        end
    end

    assign sel_idx = sel_start + sel_first;

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        bin_next    = bin_reg;
        onehot_next = onehot_reg;
        valid_next  = valid_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next  = HOLD;
                    bin_next    = sel_idx;
                    onehot_next = sel_onehot;
                    valid_next  = 1'b1;
                end else begin
                    bin_next    = '0;
                    onehot_next = '0;
                    valid_next  = 1'b0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ptr_next = after_bin;
                    if (|masked) begin
                        bin_next    = sel_idx;
                        onehot_next = sel_onehot;
                        valid_next  = 1'b1;
                    end else begin
                        state_next  = IDLE;
                        bin_next    = '0;
                        onehot_next = '0;
                        valid_next  = 1'b0;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                bin_next    = '0;
                onehot_next = '0;
                valid_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            bin_reg    <= '0;
            onehot_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            bin_reg    <= bin_next;
            onehot_reg <= onehot_next;
            valid_reg  <= valid_next;
        end
    end

    assign out_valid  = valid_reg;
    assign outbinbus  = bin_reg;
    assign oneshotbus = onehot_reg;
    // A grant pending during reset is dropped, so ack must not fire then.
    assign ack = rst ? '0 : (onehot_reg & {N{valid_reg & out_ready}});

endmodule

// File: tb/tb_rr_encoder.sv
// Directed bench for rr_encoder with BINBUSWIDTH = 3; expectations follow RR_ENCODER_ROUND_ROBIN_EN.
module tb_rr_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] outbinbus;
    logic [7:0] oneshotbus;
    logic [7:0] ack;

    int n_tests = 0;
    int n_fail  = 0;

    rr_encoder #(.BINBUSWIDTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .outbinbus  (outbinbus),
        .oneshotbus (oneshotbus),
        .ack        (ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rdy;
        logic       ev;
        logic [2:0] eb;
        logic [7:0] eo;
        logic [7:0] ea;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic [7:0] q, input logic y,
                                input logic v, input logic [2:0] b,
                                input logic [7:0] o, input logic [7:0] a);
        vec_t t;
        t.rst = r; t.req = q; t.rdy = y;
        t.ev = v; t.eb = b; t.eo = o; t.ea = a;
        return t;
    endfunction

    task automatic chk(input string name, input logic ev, input logic [2:0] eb,
                       input logic [7:0] eo, input logic [7:0] ea);
        n_tests++;
        if (out_valid !== ev) begin
            n_fail++;
            $display("FAIL %s out_valid got %b want %b", name, out_valid, ev);
        end
        n_tests++;
        if (outbinbus !== eb) begin
            n_fail++;
            $display("FAIL %s outbinbus got %0d want %0d", name, outbinbus, eb);
        end
        n_tests++;
        if (oneshotbus !== eo) begin
            n_fail++;
            $display("FAIL %s oneshotbus got %h want %h", name, oneshotbus, eo);
        end
        n_tests++;
        if (ack !== ea) begin
            n_fail++;
            $display("FAIL %s ack got %h want %h", name, ack, ea);
        end
        $display("[TB] %s rst=%b req=%h rdy=%b -> valid=%b bin=%0d onehot=%h ack=%h",
                 name, rst, req, out_ready, out_valid, outbinbus, oneshotbus, ack);
    endtask

    // Apply inputs for one cycle, check mid-cycle, then advance past the edge.
    task automatic cyc(input string name, input logic r, input logic [7:0] q, input logic y,
                       input logic ev, input logic [2:0] eb, input logic [7:0] eo,
                       input logic [7:0] ea);
        rst = r; req = q; out_ready = y;
        #2;
        chk(name, ev, eb, eo, ea);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset (second cycle) then 8'h83 held with out_ready = 1.
        vecs[0]  = mk(1, 8'hFF, 1, 0, 3'd0, 8'h00, 8'h00);
        vecs[1]  = mk(0, 8'h83, 1, 0, 3'd0, 8'h00, 8'h00);
        vecs[2]  = mk(0, 8'h83, 1, 1, 3'd0, 8'h01, 8'h01);
        vecs[3]  = mk(0, 8'h83, 1, 1, 3'd1, 8'h02, 8'h02);
`ifdef RR_ENCODER_ROUND_ROBIN_EN
        vecs[4]  = mk(0, 8'h83, 1, 1, 3'd7, 8'h80, 8'h80);
        vecs[5]  = mk(0, 8'h83, 1, 1, 3'd0, 8'h01, 8'h01);
        vecs[6]  = mk(0, 8'h83, 1, 1, 3'd1, 8'h02, 8'h02);
        vecs[7]  = mk(0, 8'h00, 1, 1, 3'd7, 8'h80, 8'h80);
`else
        vecs[4]  = mk(0, 8'h83, 1, 1, 3'd0, 8'h01, 8'h01);
        vecs[5]  = mk(0, 8'h83, 1, 1, 3'd1, 8'h02, 8'h02);
        vecs[6]  = mk(0, 8'h83, 1, 1, 3'd0, 8'h01, 8'h01);
        vecs[7]  = mk(0, 8'h00, 1, 1, 3'd1, 8'h02, 8'h02);
`endif
        // Single request to index 5, held for 4 cycles despite req changes.
        vecs[8]  = mk(0, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00);
        vecs[9]  = mk(0, 8'h20, 0, 0, 3'd0, 8'h00, 8'h00);
        vecs[10] = mk(0, 8'h20, 0, 1, 3'd5, 8'h20, 8'h00);
        vecs[11] = mk(0, 8'h00, 0, 1, 3'd5, 8'h20, 8'h00);
        vecs[12] = mk(0, 8'h01, 0, 1, 3'd5, 8'h20, 8'h00);
        vecs[13] = mk(0, 8'h00, 0, 1, 3'd5, 8'h20, 8'h00);
        vecs[14] = mk(0, 8'h00, 1, 1, 3'd5, 8'h20, 8'h20);
        vecs[15] = mk(0, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00);

        rst = 1'b1; req = 8'hFF; out_ready = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].rdy,
                vecs[i].ev, vecs[i].eb, vecs[i].eo, vecs[i].ea);
        end

        // Wrap-around: accept index 7, then 8'h81 twice.
        cyc("wrap_req7",    0, 8'h80, 0, 0, 3'd0, 8'h00, 8'h00);
        cyc("wrap_acc7",    0, 8'h80, 1, 1, 3'd7, 8'h80, 8'h80);
        cyc("wrap_req81a",  0, 8'h81, 0, 0, 3'd0, 8'h00, 8'h00);
        cyc("wrap_grant0",  0, 8'h00, 1, 1, 3'd0, 8'h01, 8'h01);
        cyc("wrap_req81b",  0, 8'h81, 0, 0, 3'd0, 8'h00, 8'h00);
`ifdef RR_ENCODER_ROUND_ROBIN_EN
        cyc("wrap_grant7",  0, 8'h00, 1, 1, 3'd7, 8'h80, 8'h80);
`else
        cyc("fixed_grant0", 0, 8'h00, 1, 1, 3'd0, 8'h01, 8'h01);
`endif
        cyc("wrap_idle",    0, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00);

        // Reset mid-operation: move ptr off 0, hold grant 3, reset with out_ready = 1.
        cyc("mid_req3a",    0, 8'h08, 0, 0, 3'd0, 8'h00, 8'h00);
        cyc("mid_acc3",     0, 8'h00, 1, 1, 3'd3, 8'h08, 8'h08);
        cyc("mid_req3b",    0, 8'h08, 0, 0, 3'd0, 8'h00, 8'h00);
        cyc("mid_hold3",    0, 8'h08, 0, 1, 3'd3, 8'h08, 8'h00);
        cyc("mid_rst",      1, 8'h08, 1, 1, 3'd3, 8'h08, 8'h00);
        cyc("mid_after",    0, 8'h09, 0, 0, 3'd0, 8'h00, 8'h00);
        cyc("mid_ptr0",     0, 8'h00, 1, 1, 3'd0, 8'h01, 8'h01);
        cyc("mid_req3c",    0, 8'h08, 0, 0, 3'd0, 8'h00, 8'h00);
        cyc("mid_regrant3", 0, 8'h00, 1, 1, 3'd3, 8'h08, 8'h08);
        cyc("mid_idle",     0, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
